// File: rtl/riscv_pkg.sv
// ============================================================================
// riscv_pkg -- shared constants and fetch FSM encoding for the fetch/decode/ALU
// Revision: 1.0
// ============================================================================
`default_nettype none

package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] EBREAK = 32'h0010_0073;

    typedef enum logic [1:0] {
        FS_BOOT = 2'd0,
        FS_RUN  = 2'd1,
        FS_HALT = 2'd2
    } fetch_state_e;

    // Plain-vector aliases of the enum for code that stores state as logic
    localparam logic [1:0] ST_BOOT = FS_BOOT;
    localparam logic [1:0] ST_RUN  = FS_RUN;
    localparam logic [1:0] ST_HALT = FS_HALT;

endpackage

`default_nettype wire

// File: rtl/instr_mem.sv
// ============================================================================
// instr_mem -- instruction memory, asynchronous read, synchronous write
// Revision: 1.0
// ============================================================================
`default_nettype none

module instr_mem
    import riscv_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [XLEN-1:0]          wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [XLEN-1:0]          rdata
);

    logic [XLEN-1:0] mem [DEPTH];

    // No reset: contents are loaded through the write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

`default_nettype wire

// File: rtl/instr_fetch.sv
// ============================================================================
// instr_fetch -- fetch stage: BOOT/RUN/HALT FSM, fetch pointer, output regs
// Revision: 1.0
// ============================================================================
`default_nettype none

module instr_fetch
    import riscv_pkg::*;
#(
    parameter int              DEPTH    = 64,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     prog_we,
    input  logic [$clog2(DEPTH)-1:0] prog_addr,
    input  logic [XLEN-1:0]          prog_data,
    input  logic                     redirect,
    input  logic [XLEN-1:0]          redirect_pc,
    input  logic                     ready,
    output logic                     valid,
    output logic [XLEN-1:0]          Instruction,
    output logic [XLEN-1:0]          PC,
    output logic                     misalign
);

    localparam int AW = $clog2(DEPTH);

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] fpc_q, fpc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            valid_q, valid_d;
    logic            misalign_q, misalign_d;

    logic [XLEN-1:0] target;
    logic [AW-1:0]   rd_idx;
    logic [XLEN-1:0] rd_data;

    assign target = {redirect_pc[XLEN-1:2], 2'b00};
    // One read port: a redirect reads its target, otherwise the fetch pointer
    assign rd_idx = redirect ? target[AW+1:2] : fpc_q[AW+1:2];

    instr_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (prog_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (rd_idx),
        .rdata (rd_data)
    );

    always_comb begin
        state_d    = state_q;
        fpc_d      = fpc_q;
        instr_d    = instr_q;
        pc_d       = pc_q;
        valid_d    = valid_q;
        misalign_d = misalign_q | (redirect & (redirect_pc[1:0] != 2'b00));

        if (redirect) begin
            instr_d = rd_data;
            pc_d    = target;
            fpc_d   = target + 32'd4;
            valid_d = 1'b1;
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_BOOT: begin
                    instr_d = rd_data;
                    pc_d    = fpc_q;
                    fpc_d   = fpc_q + 32'd4;
                    valid_d = 1'b1;
                    state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (valid_q && ready) begin
                        if (instr_q == EBREAK) begin
                            valid_d = 1'b0;
                            state_d = ST_HALT;
                        end else begin
                            instr_d = rd_data;
                            pc_d    = fpc_q;
                            fpc_d   = fpc_q + 32'd4;
                        end
                    end
                end
                ST_HALT: begin
                    valid_d = 1'b0;
                end
                default: begin
                    state_d = ST_BOOT;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_BOOT;
            fpc_q      <= RESET_PC;
            instr_q    <= '0;
            pc_q       <= '0;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fpc_q      <= fpc_d;
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            misalign_q <= misalign_d;
        end
    end

    assign valid       = valid_q;
    assign Instruction = instr_q;
    assign PC          = pc_q;
    assign misalign    = misalign_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// ============================================================================
// tb_instr_fetch -- directed scoreboard bench for instr_fetch
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_instr_fetch;

    localparam int DEPTH = 64;
    localparam int AW    = $clog2(DEPTH);

    logic            clk;
    logic            rst;
    logic            prog_we;
    logic [AW-1:0]   prog_addr;
    logic [31:0]     prog_data;
    logic            redirect;
    logic [31:0]     redirect_pc;
    logic            ready;
    logic            valid;
    logic [31:0]     Instruction;
    logic [31:0]     PC;
    logic            misalign;

    instr_fetch #(
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .ready       (ready),
        .valid       (valid),
        .Instruction (Instruction),
        .PC          (PC),
        .misalign    (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    logic [31:0] img [DEPTH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic [31:0] instr);
        exp_t e;
        e.pc    = pc;
        e.instr = instr;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance one edge and compare the presented instruction to the scoreboard head
    task automatic tick_check(input string tag);
        exp_t e;
        tick();
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_valid"}, {31'd0, valid}, 32'd1);
            chk({tag, "_pc"}, PC, e.pc);
            chk({tag, "_instr"}, Instruction, e.instr);
        end
    endtask

    initial begin
        rst         = 1'b0;
        prog_we     = 1'b0;
        prog_addr   = '0;
        prog_data   = '0;
        redirect    = 1'b0;
        redirect_pc = '0;
        ready       = 1'b0;

        for (int i = 0; i < DEPTH; i++) img[i] = 32'h0000_0013 + (i << 20);
        img[0]  = 32'h0020_82B3;
        img[1]  = 32'h4020_82B3;
        img[2]  = 32'h00C5_F533;
        img[3]  = 32'h0010_0073;
        img[63] = 32'h1111_1111;

        // Load memory while held in reset
        tick();
        for (int i = 0; i < DEPTH; i++) begin
            prog_we   = 1'b1;
            prog_addr = AW'(i);
            prog_data = img[i];
            tick();
        end
        prog_we = 1'b0;

        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_pc", PC, 32'd0);
        chk("rst_instr", Instruction, 32'd0);
        chk("rst_misalign", {31'd0, misalign}, 32'd0);

        // Boot and stream
        ready = 1'b1;
        rst   = 1'b1;
        push_exp(32'd0, img[0]);
        tick_check("boot_pc0");
        push_exp(32'd4, img[1]);
        tick_check("run_pc4");

        // Stall three cycles on PC=4
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push_exp(32'd4, img[1]);
            tick_check("stall_pc4");
        end
        ready = 1'b1;
        push_exp(32'd8, img[2]);
        tick_check("resume_pc8");
        push_exp(32'd12, img[3]);
        tick_check("ebreak_pc12");

        // EBREAK accepted: halt for ten cycles
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("halt_valid", {31'd0, valid}, 32'd0);
        end
        chk("halt_pc_hold", PC, 32'd12);

        // Restart from HALT via redirect
        redirect    = 1'b1;
        redirect_pc = 32'h4;
        push_exp(32'd4, img[1]);
        tick_check("redir_pc4");
        redirect = 1'b0;
        push_exp(32'd8, img[2]);
        tick_check("redir_next_pc8");

        // Wrap past the end of memory
        redirect    = 1'b1;
        redirect_pc = 32'hFC;
        push_exp(32'hFC, img[63]);
        tick_check("redir_fc");
        chk("no_misalign", {31'd0, misalign}, 32'd0);
        redirect = 1'b0;
        push_exp(32'h100, img[0]);
        tick_check("wrap_100");

        // Misaligned redirect still proceeds, flag is sticky
        redirect    = 1'b1;
        redirect_pc = 32'h6;
        push_exp(32'd4, img[1]);
        tick_check("misal_pc4");
        chk("misal_set", {31'd0, misalign}, 32'd1);
        redirect = 1'b0;
        ready    = 1'b0;
        push_exp(32'd4, img[1]);
        tick_check("misal_hold");
        chk("misal_sticky", {31'd0, misalign}, 32'd1);

        // Asynchronous reset mid-stream with a redirect pending
        #2;
        redirect    = 1'b1;
        redirect_pc = 32'h8;
        rst         = 1'b0;
        #1;
        chk("arst_valid", {31'd0, valid}, 32'd0);
        chk("arst_pc", PC, 32'd0);
        chk("arst_instr", Instruction, 32'd0);
        chk("arst_misalign", {31'd0, misalign}, 32'd0);
        tick();
        redirect = 1'b0;
        ready    = 1'b1;
        rst      = 1'b1;
        push_exp(32'd0, img[0]);
        tick_check("reboot_pc0");
        push_exp(32'd4, img[1]);
        tick_check("reboot_pc4");

        chk("sb_drained", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
